fifo_uart_tx: RTL

Read-side consumer of the byte FIFO. The FIFO is filled by the write-side sequencer that streams an incrementing byte pattern until full. This block pops bytes whenever the FIFO is non-empty and serialises each one onto the board UART TX pin as 8N1, LSB first, at a fixed baud rate. It owns the FIFO read handshake (`rdempty`/`rdreq`/`q`, normal non-showahead mode) and the TX line; nothing sits downstream except the pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 30 +++
 rtl/fifo_uart_tx.sv | 111 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Constants shared by the UART TX and future RX blocks: FSM state encodings,
// frame layout and the clocks-per-bit derivation.
package uart_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_REQ   = 3'd1;
   localparam logic [2:0] ST_LOAD  = 3'd2;
   localparam logic [2:0] ST_START = 3'd3;
   localparam logic [2:0] ST_DATA  = 3'd4;
   localparam logic [2:0] ST_STOP  = 3'd5;

   localparam int DATA_BITS  = 8;
   localparam int START_BITS = 1;
   localparam int STOP_BITS  = 1;
   localparam int FRAME_BITS = START_BITS + DATA_BITS + STOP_BITS;

   // Integer division: every bit lasts exactly this many clocks.
   function automatic int baud_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..DIV-1 while enabled, flags the last clock of
// each bit period.
module uart_baud_cnt #(
   parameter int DIV = 434
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic en,
   output logic bit_done
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] r_cnt;

   assign bit_done = en && (r_cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (en) begin
         r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from a non-showahead FIFO and sends each as an 8N1 frame,
// LSB first, on the UART TX pin; counts completed bytes.
module fifo_uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50_000_000,
   parameter int BAUD     = 115200
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rdempty,
   input  logic [7:0]  q,
   output logic        rdreq,
   output logic        txd,
   output logic        busy,
   output logic [15:0] tx_count
);

   localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
   localparam int IDX_W    = $clog2(DATA_BITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

   logic [2:0]       r_state;
   logic [2:0]       w_state_next;
   logic [7:0]       r_shift;
   logic [IDX_W-1:0] r_bit_idx;
   logic             r_txd;
   logic             r_rdreq;
   logic [15:0]      r_tx_count;
   logic             w_bit_done;
   logic             w_cnt_clear;
   logic             w_cnt_en;

   assign rdreq    = r_rdreq;
   assign txd      = r_txd;
   assign busy     = (r_state != ST_IDLE);
   assign tx_count = r_tx_count;

   // Bit timing restarts on every state change.
   assign w_cnt_clear = (w_state_next != r_state);
   assign w_cnt_en    = (r_state == ST_START) || (r_state == ST_DATA) ||
                        (r_state == ST_STOP);

   uart_baud_cnt #(
      .DIV(BAUD_DIV)
   ) u_baud_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (w_cnt_clear),
      .en       (w_cnt_en),
      .bit_done (w_bit_done)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (!rdempty) w_state_next = ST_REQ;
         ST_REQ:   w_state_next = ST_LOAD;
         ST_LOAD:  w_state_next = ST_START;
         ST_START: if (w_bit_done) w_state_next = ST_DATA;
         ST_DATA:  if (w_bit_done && (r_bit_idx == LAST_IDX)) w_state_next = ST_STOP;
         ST_STOP:  if (w_bit_done) w_state_next = rdempty ? ST_IDLE : ST_REQ;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_txd      <= 1'b1;
         r_rdreq    <= 1'b0;
         r_tx_count <= '0;
      end else begin
         r_state <= w_state_next;
         // The pop strobe exists only for the single REQ cycle.
         r_rdreq <= (w_state_next == ST_REQ);
         case (r_state)
            ST_IDLE: r_txd <= 1'b1;
            ST_LOAD: begin
               r_shift   <= q;
               r_txd     <= 1'b0;
               r_bit_idx <= '0;
            end
            ST_START: begin
               if (w_bit_done) begin
                  r_txd     <= r_shift[0];
                  r_bit_idx <= '0;
               end
            end
            ST_DATA: begin
               if (w_bit_done) begin
                  if (r_bit_idx == LAST_IDX) begin
                     r_txd <= 1'b1;
                  end else begin
                     r_shift   <= r_shift >> 1;
                     r_txd     <= r_shift[1];
                     r_bit_idx <= r_bit_idx + IDX_W'(1);
                  end
               end
            end
            ST_STOP: begin
               if (w_bit_done) r_tx_count <= r_tx_count + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
